// File: rtl/info_request_initiator.sv
// Initiator side of the InformationController request/confirm handshake with timeout and retry.
// Define INFO_LOCKOUT_EN to add the consecutive-failure lockout (LOCKED state, reset-only exit).
module info_request_initiator #(
  parameter int REQ_CYCLES = 1,
  parameter int TIMEOUT    = 8,
  parameter int MAX_RETRY  = 2
`ifdef INFO_LOCKOUT_EN
  ,
  parameter int LOCK_LIMIT = 3
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] userIn,
  input  logic [7:0] passIn,
  input  logic       target,
  input  logic       writeRegP,
  input  logic       writeRegQ,
  output logic       request,
  output logic       confirm,
  output logic [7:0] user,
  output logic [7:0] password,
  output logic       busy,
  output logic       granted,
  output logic       denied,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
`ifdef INFO_LOCKOUT_EN
    ,
    S_LOCKED = 3'd6
`endif
  } state_t;

  localparam logic [3:0] REQ_LAST   = 4'(REQ_CYCLES - 1);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);
`ifdef INFO_LOCKOUT_EN
  localparam logic [2:0] LOCK_AT    = 3'(LOCK_LIMIT);
`endif

  state_t     r_state, w_state_next;
  logic [3:0] r_req_cnt, w_req_cnt_next;
  logic [7:0] r_timer, w_timer_next;
  logic [2:0] r_retry, w_retry_next;
  logic [7:0] r_user_lat, w_user_lat_next;
  logic [7:0] r_pass_lat, w_pass_lat_next;
  logic       r_target, w_target_next;
  logic       r_fault, w_fault_next;
`ifdef INFO_LOCKOUT_EN
  logic [2:0] r_fail_cnt, w_fail_cnt_next;
`endif

  logic       r_request, r_confirm, r_busy, r_granted, r_denied;
  logic [7:0] r_user, r_pass;
  logic       w_request_next, w_confirm_next, w_busy_next, w_granted_next, w_denied_next;
  logic       w_cred_drive;
  logic [7:0] w_user_next, w_pass_next;

  logic w_strobe_ok, w_strobe_bad;

  // A wrong strobe counts as bad even when the expected one is also high.
  assign w_strobe_ok  = r_target ? writeRegQ : writeRegP;
  assign w_strobe_bad = r_target ? writeRegP : writeRegQ;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next    = r_state;
    w_req_cnt_next  = r_req_cnt;
    w_timer_next    = r_timer;
    w_retry_next    = r_retry;
    w_user_lat_next = r_user_lat;
    w_pass_lat_next = r_pass_lat;
    w_target_next   = r_target;
    w_fault_next    = r_fault;
`ifdef INFO_LOCKOUT_EN
    w_fail_cnt_next = r_fail_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_user_lat_next = userIn;
          w_pass_lat_next = passIn;
          w_target_next   = target;
          w_retry_next    = 3'd0;
          w_fault_next    = 1'b0;
          w_req_cnt_next  = 4'd0;
          w_timer_next    = 8'd0;
          w_state_next    = S_REQ;
        end
      end
      S_REQ: begin
        if (r_req_cnt == REQ_LAST) begin
          w_req_cnt_next = 4'd0;
          w_timer_next   = 8'd0;
          w_state_next   = S_WAIT;
        end else begin
          w_req_cnt_next = r_req_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        // Strobes are examined before the timer, so a strobe on the last cycle still wins.
        if (w_strobe_bad) begin
          w_fault_next = 1'b1;
          w_state_next = S_FAIL;
        end else if (w_strobe_ok) begin
          w_state_next = S_DONE;
        end else if (r_timer == TIMER_LAST) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_next = r_retry + 3'd1;
            w_state_next = S_GAP;
          end else begin
            w_state_next = S_FAIL;
          end
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
`ifdef INFO_LOCKOUT_EN
        if (w_state_next == S_FAIL && r_fail_cnt != 3'd7) w_fail_cnt_next = r_fail_cnt + 3'd1;
        if (w_state_next == S_DONE) w_fail_cnt_next = 3'd0;
`endif
      end
      S_GAP: begin
        w_timer_next = 8'd0;
        w_state_next = S_REQ;
      end
      S_DONE: w_state_next = S_IDLE;
      S_FAIL: begin
`ifdef INFO_LOCKOUT_EN
        w_state_next = (r_fail_cnt >= LOCK_AT) ? S_LOCKED : S_IDLE;
`else
        w_state_next = S_IDLE;
`endif
      end
`ifdef INFO_LOCKOUT_EN
      S_LOCKED: w_state_next = S_LOCKED;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    w_request_next = 1'b0;
    w_confirm_next = 1'b0;
    w_busy_next    = 1'b0;
    w_granted_next = 1'b0;
    w_denied_next  = 1'b0;
    w_cred_drive   = 1'b0;
    case (w_state_next)
      S_REQ: begin
        w_request_next = 1'b1;
        w_busy_next    = 1'b1;
        w_cred_drive   = 1'b1;
      end
      S_WAIT: begin
        w_request_next = 1'b1;
        w_confirm_next = 1'b1;
        w_busy_next    = 1'b1;
        w_cred_drive   = 1'b1;
      end
      S_GAP: begin
        w_busy_next  = 1'b1;
        w_cred_drive = 1'b1;
      end
      S_DONE: begin
        w_granted_next = 1'b1;
        w_busy_next    = 1'b1;
        w_cred_drive   = 1'b1;
      end
      S_FAIL: begin
        w_denied_next = 1'b1;
        w_busy_next   = 1'b1;
        w_cred_drive  = 1'b1;
      end
`ifdef INFO_LOCKOUT_EN
      S_LOCKED: w_busy_next = 1'b1;
`endif
      default: ;
    endcase
    w_user_next = w_cred_drive ? w_user_lat_next : 8'h00;
    w_pass_next = w_cred_drive ? w_pass_lat_next : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req_cnt  <= 4'd0;
      r_timer    <= 8'd0;
      r_retry    <= 3'd0;
      r_user_lat <= 8'h00;
      r_pass_lat <= 8'h00;
      r_target   <= 1'b0;
      r_fault    <= 1'b0;
      r_request  <= 1'b0;
      r_confirm  <= 1'b0;
      r_busy     <= 1'b0;
      r_granted  <= 1'b0;
      r_denied   <= 1'b0;
      r_user     <= 8'h00;
      r_pass     <= 8'h00;
`ifdef INFO_LOCKOUT_EN
      r_fail_cnt <= 3'd0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_req_cnt  <= w_req_cnt_next;
      r_timer    <= w_timer_next;
      r_retry    <= w_retry_next;
      r_user_lat <= w_user_lat_next;
      r_pass_lat <= w_pass_lat_next;
      r_target   <= w_target_next;
      r_fault    <= w_fault_next;
      r_request  <= w_request_next;
      r_confirm  <= w_confirm_next;
      r_busy     <= w_busy_next;
      r_granted  <= w_granted_next;
      r_denied   <= w_denied_next;
      r_user     <= w_user_next;
      r_pass     <= w_pass_next;
`ifdef INFO_LOCKOUT_EN
      r_fail_cnt <= w_fail_cnt_next;
`endif
    end
  end

  assign request  = r_request;
  assign confirm  = r_confirm;
  assign user     = r_user;
  assign password = r_pass;
  assign busy     = r_busy;
  assign granted  = r_granted;
  assign denied   = r_denied;
  assign fault    = r_fault;

endmodule

// File: tb/tb_info_request_initiator.sv
// Self-checking bench for info_request_initiator: table of directed transactions, hand-written
// corner sequences and random transactions against a per-transaction expected-trace model.
`timescale 1ns/1ps
module tb_info_request_initiator;

  localparam int REQ_CYCLES = 1;
  localparam int TIMEOUT    = 8;
  localparam int MAX_RETRY  = 2;
  localparam int LOCK_LIMIT = 3;
  localparam int ATTEMPTS   = MAX_RETRY + 1;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_OK    = 2'd1;
  localparam logic [1:0] K_WRONG = 2'd2;
  localparam logic [1:0] K_BOTH  = 2'd3;

  logic       clock = 1'b0;
  logic       reset, start, target, writeRegP, writeRegQ;
  logic [7:0] userIn, passIn, user, password;
  logic       request, confirm, busy, granted, denied, fault;

  info_request_initiator dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .userIn   (userIn),
    .passIn   (passIn),
    .target   (target),
    .writeRegP(writeRegP),
    .writeRegQ(writeRegQ),
    .request  (request),
    .confirm  (confirm),
    .user     (user),
    .password (password),
    .busy     (busy),
    .granted  (granted),
    .denied   (denied),
    .fault    (fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       request, confirm, busy, granted, denied, fault;
    logic [7:0] user, password;
  } outs_t;

  typedef struct packed {
    logic wait_cyc;
    logic wp, wq;
  } stim_t;

  // Per attempt: which strobe the controller answers with and on which WAIT cycle.
  typedef struct packed {
    logic [7:0]                user, pass;
    logic                      target;
    logic [ATTEMPTS-1:0][1:0]  kind;
    logic [ATTEMPTS-1:0][3:0]  delay;
    logic                      exp_granted, exp_fault;
    logic [1:0]                exp_attempts;
  } txn_t;

  int    n_checks = 0;
  int    n_errors = 0;
  int    txn_id   = 0;
  outs_t exp_q[$];
  stim_t stim_q[$];
  logic  model_fault  = 1'b0;
  int    model_fails  = 0;
  bit    model_locked = 1'b0;

  function automatic outs_t mk_out(logic rq, logic cf, logic bz, logic g, logic d, logic f,
                                   logic [7:0] u, logic [7:0] p);
    outs_t o;
    o.request = rq; o.confirm = cf; o.busy = bz; o.granted = g; o.denied = d; o.fault = f;
    o.user = u; o.password = p;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    return mk_out(request, confirm, busy, granted, denied, fault, user, password);
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("req=%b conf=%b busy=%b gnt=%b den=%b flt=%b user=%h pass=%h",
                     o.request, o.confirm, o.busy, o.granted, o.denied, o.fault, o.user, o.password);
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic txn_t mk(logic [7:0] u, logic [7:0] p, logic tg,
                              logic [1:0] k0, int d0, logic [1:0] k1, int d1,
                              logic [1:0] k2, int d2, logic g, logic f, int att);
    txn_t t;
    t.user = u; t.pass = p; t.target = tg;
    t.kind[0] = k0; t.kind[1] = k1; t.kind[2] = k2;
    t.delay[0] = 4'(d0); t.delay[1] = 4'(d1); t.delay[2] = 4'(d2);
    t.exp_granted = g; t.exp_fault = f; t.exp_attempts = 2'(att);
    return t;
  endfunction

  // Expected cycle-by-cycle trace of one transaction, built from the protocol description:
  // each attempt is REQ_CYCLES of request, then up to TIMEOUT cycles of request+confirm,
  // separated by one idle-bus gap; then one outcome cycle and the return to idle.
  task automatic build_trace(input txn_t t);
    bit done = 1'b0;
    bit gnt  = 1'b0;
    bit flt  = 1'b0;
    exp_q.delete();
    stim_q.delete();
    for (int a = 0; a < ATTEMPTS && !done; a++) begin
      for (int r = 0; r < REQ_CYCLES; r++) begin
        exp_q.push_back(mk_out(1, 0, 1, 0, 0, 0, t.user, t.pass));
        stim_q.push_back('0);
      end
      for (int w = 0; w < TIMEOUT && !done; w++) begin
        stim_t      s;
        logic [1:0] k;
        k = t.kind[a];
        s = '{1'b1, 1'b0, 1'b0};
        if (k != K_NONE && int'(t.delay[a]) == w) begin
          s.wp = (k == K_BOTH) || (k == K_OK && !t.target) || (k == K_WRONG && t.target);
          s.wq = (k == K_BOTH) || (k == K_OK && t.target) || (k == K_WRONG && !t.target);
          done = 1'b1;
          gnt  = (k == K_OK);
          flt  = (k != K_OK);
        end
        exp_q.push_back(mk_out(1, 1, 1, 0, 0, 0, t.user, t.pass));
        stim_q.push_back(s);
      end
      if (!done) begin
        if (a == ATTEMPTS - 1) done = 1'b1;
        else begin
          exp_q.push_back(mk_out(0, 0, 1, 0, 0, 0, t.user, t.pass));
          stim_q.push_back('0);
        end
      end
    end
    exp_q.push_back(mk_out(0, 0, 1, gnt, !gnt, flt, t.user, t.pass));
    stim_q.push_back('0);
    model_fault = flt;
    model_fails = gnt ? 0 : model_fails + 1;
`ifdef INFO_LOCKOUT_EN
    model_locked = (model_fails >= LOCK_LIMIT);
`endif
    exp_q.push_back(mk_out(0, 0, model_locked, 0, 0, flt, 8'h00, 8'h00));
    stim_q.push_back('0);
  endtask

  task automatic drive_quiet();
    start = 1'b0; writeRegP = 1'b0; writeRegQ = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; the start is sampled on the next rising edge.
  task automatic run_txn(input txn_t t, input bit spurious, input bit use_table);
    int    last, n_g, n_d, n_req;
    logic  prev_req;
    outs_t got;
    build_trace(t);
    last = exp_q.size() - 1;
    n_g = 0; n_d = 0; n_req = 0; prev_req = 1'b0;
    txn_id++;
    start = 1'b1; userIn = t.user; passIn = t.pass; target = t.target;
    writeRegP = 1'b0; writeRegQ = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clock);
      got = dut_outs();
      check($sformatf("txn%0d cycle%0d", txn_id, c), got, exp_q[c]);
      if (got.granted === 1'b1) n_g++;
      if (got.denied === 1'b1) n_d++;
      if (got.request === 1'b1 && prev_req !== 1'b1) n_req++;
      prev_req = got.request;
      drive_quiet();
      if (c < last) begin
        if (stim_q[c].wait_cyc) begin
          writeRegP = stim_q[c].wp; writeRegQ = stim_q[c].wq;
        end else if (spurious) begin
          writeRegP = 1'($urandom); writeRegQ = 1'($urandom);
        end
        if (spurious && $urandom_range(0, 3) == 0) begin
          start = 1'b1; userIn = 8'($urandom); passIn = 8'($urandom); target = 1'($urandom);
        end
      end
    end
    if (use_table) begin
      check_int($sformatf("txn%0d granted pulses", txn_id), n_g, int'(t.exp_granted));
      check_int($sformatf("txn%0d denied pulses", txn_id), n_d, int'(!t.exp_granted));
      check_int($sformatf("txn%0d request bursts", txn_id), n_req, int'(t.exp_attempts));
      check_int($sformatf("txn%0d final fault", txn_id), int'(fault), int'(t.exp_fault));
    end
  endtask

  task automatic idle_cycle();
    drive_quiet();
    writeRegP = 1'($urandom); writeRegQ = 1'($urandom);
    @(negedge clock);
    check("idle", dut_outs(), mk_out(0, 0, 0, 0, 0, model_fault, 8'h00, 8'h00));
  endtask

  task automatic do_reset();
    drive_quiet();
    reset = 1'b1;
    @(negedge clock);
    check("reset", dut_outs(), '0);
    reset = 1'b0;
    model_fault = 1'b0; model_fails = 0; model_locked = 1'b0;
  endtask

  // Starts are ignored while locked; only reset brings the block back.
  task automatic locked_then_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; userIn = 8'($urandom); passIn = 8'($urandom); target = 1'($urandom);
      writeRegP = 1'($urandom); writeRegQ = 1'($urandom);
      @(negedge clock);
      check("locked", dut_outs(), mk_out(0, 0, 1, 0, 0, model_fault, 8'h00, 8'h00));
    end
    do_reset();
  endtask

  txn_t vec[8];

  initial begin
    vec[0] = mk(8'hAA, 8'hAA, 0, K_OK,    2, K_NONE, 0, K_NONE,  0, 1, 0, 1);
    vec[1] = mk(8'h3C, 8'hC3, 1, K_NONE,  0, K_OK,   1, K_NONE,  0, 1, 0, 2);
    vec[2] = mk(8'h55, 8'h66, 1, K_NONE,  0, K_NONE, 0, K_NONE,  0, 0, 0, 3);
    vec[3] = mk(8'h11, 8'h22, 0, K_WRONG, 1, K_OK,   0, K_NONE,  0, 0, 1, 1);
    vec[4] = mk(8'h33, 8'h44, 0, K_BOTH,  0, K_OK,   0, K_NONE,  0, 0, 1, 1);
    vec[5] = mk(8'h77, 8'h88, 1, K_OK,    7, K_NONE, 0, K_NONE,  0, 1, 0, 1);
    vec[6] = mk(8'h99, 8'h9A, 1, K_NONE,  0, K_NONE, 0, K_WRONG, 4, 0, 1, 3);
    vec[7] = mk(8'h0F, 8'hF0, 0, K_OK,    9, K_OK,   0, K_NONE,  0, 1, 0, 2);

    drive_quiet();
    userIn = 8'h00; passIn = 8'h00; target = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    do_reset();
    idle_cycle();

    for (int i = 0; i < 8; i++) begin
      run_txn(vec[i], 1'b0, 1'b1);
      if (model_locked) locked_then_reset();
    end

    // Second start in REQ is ignored; reset in WAIT releases the bus on the next cycle.
    drive_quiet();
    start = 1'b1; userIn = 8'h2B; passIn = 8'h5C; target = 1'b0;
    @(negedge clock);
    check("busy start REQ", dut_outs(), mk_out(1, 0, 1, 0, 0, 0, 8'h2B, 8'h5C));
    start = 1'b1; userIn = 8'h00; passIn = 8'h00; target = 1'b1;
    @(negedge clock);
    check("ignored start WAIT", dut_outs(), mk_out(1, 1, 1, 0, 0, 0, 8'h2B, 8'h5C));
    do_reset();
    idle_cycle();

`ifdef INFO_LOCKOUT_EN
    for (int i = 0; i < LOCK_LIMIT; i++) run_txn(vec[2], 1'b0, 1'b0);
    check_int("lock reached", int'(busy), 1);
    locked_then_reset();
`endif

    for (int i = 0; i < 40; i++) begin
      txn_t t;
      t.user = 8'($urandom); t.pass = 8'($urandom); t.target = 1'($urandom);
      for (int a = 0; a < ATTEMPTS; a++) begin
        int r;
        r = $urandom_range(0, 9);
        t.kind[a]  = (r < 5) ? K_NONE : (r < 8) ? K_OK : (r == 8) ? K_WRONG : K_BOTH;
        t.delay[a] = 4'($urandom_range(0, TIMEOUT + 3));
      end
      t.exp_granted = 1'b0; t.exp_fault = 1'b0; t.exp_attempts = 2'd0;
      run_txn(t, 1'b1, 1'b0);
      if (model_locked) locked_then_reset();
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
